// File: rtl/serdes_test_pkg.sv
// serdes_test_pkg: aligner state encoding and default training/timing constants
package serdes_test_pkg;
   typedef enum logic [2:0] {ST_SEARCH, ST_SLIP, ST_SETTLE, ST_VERIFY, ST_LOCKED, ST_FAIL} state_t;
   localparam int DEF_DATA_WIDTH = 8;
   localparam logic [7:0] DEF_TRAIN_WORD = 8'h6B;
   localparam int DEF_SETTLE_CYCLES = 3;
   localparam int DEF_LOCK_COUNT = 16;
   localparam int DEF_LOSS_COUNT = 4;
endpackage

// File: rtl/sat_counter.sv
// sat_counter: clearable up-counter that holds at all-ones instead of wrapping
module sat_counter #(
   parameter int W = 16
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         clr,
   input  logic         inc,
   output logic [W-1:0] q
);
   always_ff @(posedge clk) begin
      if (rst || clr) q <= '0;
      else if (inc && !(&q)) q <= q + 1'b1;
   end
endmodule

// File: rtl/serdes_rx_aligner.sv
// serdes_rx_aligner: finds ISERDES word alignment by pulsing BITSLIP until the training word
// is seen LOCK_COUNT times in a row, then monitors the locked link for errors and loss.
module serdes_rx_aligner
   import serdes_test_pkg::*;
#(
   parameter int         DATA_WIDTH    = DEF_DATA_WIDTH,
   parameter logic [7:0] TRAIN_WORD    = DEF_TRAIN_WORD,
   parameter int         SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int         LOCK_COUNT    = DEF_LOCK_COUNT,
   parameter int         LOSS_COUNT    = DEF_LOSS_COUNT,
   parameter int         MAX_SLIPS     = 2 * DATA_WIDTH
) (
   input  logic                  clkdiv,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] rx_data,
   input  logic                  restart,
   output logic                  bitslip,
   output logic                  aligned,
   output logic                  fail,
   output logic [3:0]            slip_cnt,
   output logic [15:0]           err_cnt
);
   state_t state, next;
   logic [15:0] cnt, cnt_nxt;
   logic [4:0] slips, slips_nxt;
   logic match;
   assign match = rx_data == TRAIN_WORD[DATA_WIDTH-1:0];
   // slips can reach 16 with default MAX_SLIPS; the 4-bit view holds at 15
   assign slip_cnt = slips[4] ? 4'hF : slips[3:0];
   // cnt is shared: settle wait, match run and miss run live in mutually exclusive states
   always_comb begin
      next = state;
      cnt_nxt = cnt;
      slips_nxt = slips;
      if (restart) begin
         next = ST_SEARCH;
         cnt_nxt = '0;
         slips_nxt = '0;
      end else begin
         case (state)
            ST_SEARCH: begin
               next = match ? ST_VERIFY : ST_SLIP;
               cnt_nxt = match ? 16'd1 : 16'd0;
            end
            ST_SLIP: begin
               next = ST_SETTLE;
               cnt_nxt = '0;
               slips_nxt = slips + 5'd1;
            end
            ST_SETTLE: begin
               cnt_nxt = cnt + 16'd1;
               if (cnt == 16'(SETTLE_CYCLES - 1)) begin
                  next = slips == 5'(MAX_SLIPS) ? ST_FAIL : ST_SEARCH;
                  cnt_nxt = '0;
               end
            end
            ST_VERIFY: begin
               cnt_nxt = cnt + 16'd1;
               if (!match) begin
                  next = ST_SLIP;
                  cnt_nxt = '0;
               end else if (cnt == 16'(LOCK_COUNT - 1)) begin
                  next = ST_LOCKED;
                  cnt_nxt = '0;
               end
            end
            ST_LOCKED: begin
               cnt_nxt = match ? 16'd0 : cnt + 16'd1;
               if (!match && cnt == 16'(LOSS_COUNT - 1)) begin
                  next = ST_SEARCH;
                  cnt_nxt = '0;
                  slips_nxt = '0;
               end
            end
            default: ;
         endcase
      end
   end
   always_ff @(posedge clkdiv) begin
      if (rst) begin
         state <= ST_SEARCH;
         cnt <= '0;
         slips <= '0;
         bitslip <= 1'b0;
         aligned <= 1'b0;
         fail <= 1'b0;
      end else begin
         state <= next;
         cnt <= cnt_nxt;
         slips <= slips_nxt;
         bitslip <= next == ST_SLIP;
         aligned <= state == ST_LOCKED && !restart;
         fail <= state == ST_FAIL && !restart;
      end
   end
   sat_counter #(.W(16)) u_err (
      .clk (clkdiv),
      .rst (rst),
      .clr (restart),
      .inc (state == ST_LOCKED && !match),
      .q   (err_cnt)
   );
endmodule

// File: tb/tb_serdes_rx_aligner.sv
// tb_serdes_rx_aligner: directed scenarios checked every cycle against a behavioural link model,
// plus literal expectations for lock latency, slip counts, loss, saturation, fail and reset.
module tb_serdes_rx_aligner;
   localparam logic [7:0] TW = 8'h6B;
   localparam int M_HUNT = 0, M_SLIPPING = 1, M_WAIT = 2, M_CONF = 3, M_LOCK = 4, M_DEAD = 5;
   logic clk = 1'b0, rst = 1'b1, restart = 1'b0;
   logic [7:0] rx_data = TW;
   logic bitslip, aligned, fail;
   logic [3:0] slip_cnt;
   logic [15:0] err_cnt;
   int tests = 0, fails = 0;
   int cyc = 0, pulses = 0, last_bs = -1, min_gap = 1000;
   bit iserdes = 0, d1 = 0, d2 = 0, ld = 0;
   int rot = 0;
   always #5 clk = ~clk;
   serdes_rx_aligner dut (
      .clkdiv  (clk),
      .rst     (rst),
      .rx_data (rx_data),
      .restart (restart),
      .bitslip (bitslip),
      .aligned (aligned),
      .fail    (fail),
      .slip_cnt(slip_cnt),
      .err_cnt (err_cnt)
   );
   // link model: what each output must be after every edge, derived from the behavioural rules
   int mode = M_HUNT, wleft = 0, good = 0, bad = 0, slips = 0, err = 0, base = 0;
   bit e_bs = 0, e_al = 0, e_fl = 0, ok = 0;
   always @(posedge clk) begin
      if (rst) begin
         mode = M_HUNT; wleft = 0; good = 0; bad = 0; slips = 0; err = 0;
         e_bs = 0; e_al = 0; e_fl = 0;
      end else begin
         ok = rx_data == TW;
         base = ld ? 32'hFFFE : err;
         e_al = mode == M_LOCK && !restart;
         e_fl = mode == M_DEAD && !restart;
         err = restart ? 0 : (mode == M_LOCK && !ok && base < 32'hFFFF) ? base + 1 : base;
         if (restart) begin
            mode = M_HUNT; wleft = 0; good = 0; bad = 0; slips = 0;
         end else begin
            case (mode)
               M_HUNT: if (ok) begin mode = M_CONF; good = 1; end else mode = M_SLIPPING;
               M_SLIPPING: begin slips++; mode = M_WAIT; wleft = 3; end
               M_WAIT: begin
                  wleft--;
                  if (wleft == 0) mode = (slips == 16) ? M_DEAD : M_HUNT;
               end
               M_CONF: if (!ok) mode = M_SLIPPING;
                       else begin good++; if (good == 16) begin mode = M_LOCK; bad = 0; end end
               M_LOCK: begin
                  bad = ok ? 0 : bad + 1;
                  if (bad == 4) begin mode = M_HUNT; slips = 0; bad = 0; end
               end
               default: ;
            endcase
         end
         e_bs = mode == M_SLIPPING;
      end
   end
   function automatic logic [7:0] rotl(logic [7:0] v, int r);
      int k;
      k = r % 8;
      return (v << k) | (v >> (8 - k));
   endfunction
   task automatic chk(string name, int act, int exp);
      tests++;
      if (act != exp) begin
         fails++;
         $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, exp, $time);
      end
   endtask
   // one cycle: compare against the model at the negedge, then advance the ISERDES model
   task automatic tick();
      @(negedge clk);
      cyc++;
      chk("m_bitslip", int'(bitslip), int'(e_bs));
      chk("m_aligned", int'(aligned), int'(e_al));
      chk("m_fail", int'(fail), int'(e_fl));
      chk("m_slip_cnt", int'(slip_cnt), slips > 15 ? 15 : slips);
      chk("m_err_cnt", int'(err_cnt), err);
      if (bitslip) begin
         pulses++;
         if (last_bs >= 0 && cyc - last_bs < min_gap) min_gap = cyc - last_bs;
         last_bs = cyc;
      end
      if (iserdes) begin
         if (d2) rot++;
         d2 = d1;
         d1 = bitslip;
         rx_data = rotl(TW, rot);
      end
   endtask
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "timeout");
   end
   initial begin
      repeat (3) tick();
      chk("rst_bitslip", int'(bitslip), 0);
      chk("rst_aligned", int'(aligned), 0);
      chk("rst_fail", int'(fail), 0);
      chk("rst_err", int'(err_cnt), 0);
      rst = 1'b0;
      repeat (16) tick();
      chk("lock_c16", int'(aligned), 0);
      tick();
      chk("lock_c17", int'(aligned), 1);
      chk("lock_slips", int'(slip_cnt), 0);
      chk("lock_pulses", pulses, 0);
      rx_data = 8'h00;
      repeat (3) tick();
      rx_data = TW;
      tick();
      chk("err3", int'(err_cnt), 3);
      chk("still_aligned", int'(aligned), 1);
      rx_data = 8'h00;
      repeat (4) tick();
      rx_data = TW;
      tick();
      chk("loss_aligned", int'(aligned), 0);
      chk("loss_err", int'(err_cnt), 7);
      chk("loss_slips", int'(slip_cnt), 0);
      repeat (20) tick();
      chk("relock", int'(aligned), 1);
      force dut.u_err.q = 16'hFFFE;
      ld = 1;
      #1 release dut.u_err.q;
      rx_data = 8'h00;
      tick();
      ld = 0;
      rx_data = TW;
      tick();
      for (int i = 0; i < 3; i++) begin
         rx_data = 8'h00;
         repeat (2) tick();
         rx_data = TW;
         tick();
      end
      chk("sat_err", int'(err_cnt), 65535);
      chk("sat_aligned", int'(aligned), 1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("restart_err", int'(err_cnt), 0);
      chk("restart_aligned", int'(aligned), 0);
      rot = 3; d1 = 0; d2 = 0; iserdes = 1;
      rx_data = rotl(TW, rot);
      pulses = 0; last_bs = -1; min_gap = 1000;
      for (int i = 0; i < 300 && !aligned; i++) tick();
      chk("rot_aligned", int'(aligned), 1);
      chk("rot_pulses", pulses, 5);
      chk("rot_gap_ge4", int'(min_gap >= 4), 1);
      chk("rot_slips", int'(slip_cnt), 5);
      iserdes = 0;
      rx_data = 8'h00;
      restart = 1'b1;
      tick();
      restart = 1'b0;
      pulses = 0; last_bs = -1; min_gap = 1000;
      for (int i = 0; i < 400 && !fail; i++) tick();
      chk("fail_set", int'(fail), 1);
      chk("fail_pulses", pulses, 16);
      repeat (20) tick();
      chk("fail_sticky", int'(fail), 1);
      chk("fail_no_more", pulses, 16);
      chk("fail_slips", int'(slip_cnt), 15);
      chk("fail_gap_ge4", int'(min_gap >= 4), 1);
      restart = 1'b1;
      tick();
      restart = 1'b0;
      chk("fail_cleared", int'(fail), 0);
      chk("fail_slips_clr", int'(slip_cnt), 0);
      for (int i = 0; i < 20 && !bitslip; i++) tick();
      chk("bs_seen", int'(bitslip), 1);
      rst = 1'b1;
      tick();
      chk("rstbs_bitslip", int'(bitslip), 0);
      chk("rstbs_aligned", int'(aligned), 0);
      chk("rstbs_fail", int'(fail), 0);
      chk("rstbs_slips", int'(slip_cnt), 0);
      chk("rstbs_err", int'(err_cnt), 0);
      rst = 1'b0;
      repeat (2) tick();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end
endmodule
